// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle arithmetic/logic ops plus an iterative
// shift-add multiply, with a one-entry result register under backpressure.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    input  logic [3:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] R,
    output logic             zero,
    output logic             carry,
    output logic             sign,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   r_q;
    logic               carry_q;
    logic               ovf_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    logic               accept;
    logic               is_mul;
    logic [2*WIDTH-1:0] acc_d;

    logic [WIDTH-1:0]   x, y, r_d;
    logic               ci, is_arith, is_sub;
    logic               carry_d, ovf_d;
    logic [WIDTH:0]     zsum;

    assign in_ready  = (state_q == IDLE) | ((state_q == HOLD) & out_ready);
    assign accept    = in_valid & in_ready;
    assign is_mul    = (Op == 4'h9);
    assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);

    assign out_valid = (state_q == HOLD);
    assign R         = r_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign sign      = r_q[WIDTH-1];
    assign zero      = out_valid & ~|r_q;

    // Every arithmetic op is folded into x + y + ci on one adder.
    always_comb begin
        x        = A;
        y        = '0;
        ci       = c_in;
        is_arith = 1'b0;
        is_sub   = 1'b0;
        r_d      = '0;
        carry_d  = 1'b0;
        ovf_d    = 1'b0;
        unique case (Op)
            4'h0: is_arith = 1'b1;
            4'h1: begin
                x        = ~A;
                y        = WIDTH'(1);
                is_arith = 1'b1;
            end
            4'h2: begin
                y        = B;
                is_arith = 1'b1;
            end
            4'h3: begin
                y        = WIDTH'(1);
                is_arith = 1'b1;
            end
            4'h4: r_d = A & B;
            4'h5: r_d = A | B;
            4'h6: r_d = A ^ B;
            4'h7: r_d = ~A;
            4'h8: begin
                y        = ~B;
                ci       = ~c_in;
                is_arith = 1'b1;
                is_sub   = 1'b1;
            end
            default: ;
        endcase
        zsum = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
        if (is_arith) begin
            r_d     = zsum[WIDTH-1:0];
            carry_d = zsum[WIDTH] ^ is_sub;
            ovf_d   = (x[WIDTH-1] == y[WIDTH-1]) &
                      (zsum[WIDTH-1] != x[WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            r_q      <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            unique case (state_q)
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_q <= HOLD;
                        r_q     <= acc_d[WIDTH-1:0];
                        carry_q <= |acc_d[2*WIDTH-1:WIDTH];
                        ovf_q   <= 1'b0;
                    end
                end
                HOLD: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: ;
            endcase
            // Accept only happens in IDLE or a draining HOLD.
            if (accept) begin
                if (is_mul) begin
                    state_q  <= MUL;
                    acc_q    <= '0;
                    mcand_q  <= {{WIDTH{1'b0}}, A};
                    mplier_q <= B;
                    cnt_q    <= '0;
                end else begin
                    state_q <= HOLD;
                    r_q     <= r_d;
                    carry_q <= carry_d;
                    ovf_q   <= ovf_d;
                end
            end
        end
    end

endmodule
